gpi_pad_filter: RTL and testbench

- Digital front-end that sits directly downstream of a pull-up GPI pad cell.
- Drives the pad's input-enable and Schmitt-trigger-enable pins, and consumes the pad's DI output.
- Synchronises and debounces the pad level in the core clock domain, then produces a clean level, single-cycle edge pulses and a sticky maskable interrupt for the core.

---
 rtl/gpi_pad_filter_if.sv | 31 +++
 rtl/gpi_pad_filter.sv | 159 +++++++++++++++
 tb/tb_gpi_pad_filter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpi_pad_filter_if.sv
// Core/pad-facing signal bundle of the GPI pad filter.
// The slave modport is the filter itself; master is whoever drives it.
interface gpi_pad_filter_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       ste_cfg;
  logic [CNT_W-1:0] debounce;
  logic [1:0]       irq_mask;
  logic             irq_clr;
  logic             cnt_clr;
  logic [1:0]       di;
  logic             ie;
  logic [1:0]       ste;
  logic             level;
  logic             valid;
  logic             rise;
  logic             fall;
  logic             irq;
  logic [15:0]      edge_cnt;

  modport master (
    output en, ste_cfg, debounce, irq_mask, irq_clr, cnt_clr, di,
    input  ie, ste, level, valid, rise, fall, irq, edge_cnt
  );

  modport slave (
    input  en, ste_cfg, debounce, irq_mask, irq_clr, cnt_clr, di,
    output ie, ste, level, valid, rise, fall, irq, edge_cnt
  );
endinterface

// File: rtl/gpi_pad_filter.sv
// GPI pad front-end: synchroniser, debounce FSM, edge pulses and sticky irq.
// Define GPI_FILTER_EDGE_COUNT_EN to build the saturating qualified-edge counter.
//
// state   | meaning
// OFF     | channel disabled, pad input buffer off
// SETTLE  | pad just enabled, waiting for receiver and synchroniser to settle
// STABLE  | level is trusted and matches the synchronised pad
// QUALIFY | pad differs from level, counting consecutive samples
module gpi_pad_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   CNT_W         = 8,
  parameter int   SETTLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  gpi_pad_filter_if.slave bus
);

  typedef enum logic [1:0] {OFF, SETTLE, STABLE, QUALIFY} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             valid_q, valid_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ie_q;
  logic [1:0]       ste_q;
  logic             irq_q;
  logic             irq_set;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s;

  // Bit1 of the pad output is a redundant copy and is deliberately not used.
  logic unused_di;
  assign unused_di = bus.di[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.di[0]};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!bus.en) begin
      state_d = OFF;
      cnt_d   = '0;
      level_d = RESET_LEVEL;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            level_d = s;
            valid_d = 1'b1;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE: begin
          if (s != level_q) begin
            if (bus.debounce == '0) begin
              level_d = s;
              rise_d  = s;
              fall_d  = ~s;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = QUALIFY;
            end
          end
        end
        QUALIFY: begin
          // The >= compare lets a lowered debounce length take effect at once.
          if (s == level_q) begin
            state_d = STABLE;
          end else if (cnt_q >= bus.debounce) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign irq_set = (rise_q & bus.irq_mask[0]) | (fall_q & bus.irq_mask[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ie_q    <= 1'b0;
      ste_q   <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ie_q    <= (state_d != OFF);
      ste_q   <= bus.en ? bus.ste_cfg : 2'b00;
      irq_q   <= irq_set | (irq_q & ~bus.irq_clr);
    end
  end

  assign bus.ie    = ie_q;
  assign bus.ste   = ste_q;
  assign bus.level = level_q;
  assign bus.valid = valid_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.irq   = irq_q;

`ifdef GPI_FILTER_EDGE_COUNT_EN
  logic [15:0] edge_cnt_q;
  logic        edge_seen;

  assign edge_seen = rise_q | fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                edge_cnt_q <= 16'd0;
    else if (bus.cnt_clr)                      edge_cnt_q <= {15'd0, edge_seen};
    else if (edge_seen && edge_cnt_q != 16'hFFFF) edge_cnt_q <= edge_cnt_q + 16'd1;
  end

  assign bus.edge_cnt = edge_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.edge_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_gpi_pad_filter.sv
// Directed plus randomized bench for gpi_pad_filter against a run-length reference model.
// Honours GPI_FILTER_EDGE_COUNT_EN for the edge counter expectations.
module tb_gpi_pad_filter;
  localparam int   SYNC_STAGES   = 2;
  localparam int   CNT_W         = 8;
  localparam int   SETTLE_CYCLES = 4;
  localparam logic RESET_LEVEL   = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpi_pad_filter_if #(.CNT_W(CNT_W)) bus ();

  gpi_pad_filter #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W),
    .SETTLE_CYCLES(SETTLE_CYCLES), .RESET_LEVEL(RESET_LEVEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: enable/elapsed time and a run length of disagreeing samples.
  logic       m_on, m_valid, m_level, m_rise, m_fall, m_irq, m_ie;
  logic [1:0] m_ste;
  int         m_elapsed, m_run, m_edges;
  logic       msync [SYNC_STAGES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_valid = 0; m_level = RESET_LEVEL; m_rise = 0; m_fall = 0;
    m_irq = 0; m_ie = 0; m_ste = 2'b00; m_elapsed = 0; m_run = 0; m_edges = 0;
    for (int i = 0; i < SYNC_STAGES; i++) msync[i] = RESET_LEVEL;
  endtask

  task automatic cyc();
    logic s_old, prev_edge, n_rise, n_fall;
    s_old     = msync[SYNC_STAGES-1];
    prev_edge = m_rise | m_fall;
    n_rise    = 0;
    n_fall    = 0;
    if (!bus.en) begin
      m_on = 0; m_valid = 0; m_level = RESET_LEVEL; m_run = 0; m_elapsed = 0;
    end else if (!m_on) begin
      m_on = 1; m_elapsed = 0;
    end else if (!m_valid) begin
      m_elapsed++;
      if (m_elapsed == SETTLE_CYCLES + SYNC_STAGES) begin
        m_level = s_old; m_valid = 1; m_run = 0;
      end
    end else if (s_old != m_level) begin
      m_run++;
      if (m_run >= int'(bus.debounce) + 1) begin
        m_level = s_old; n_rise = s_old; n_fall = ~s_old; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_irq = (m_rise & bus.irq_mask[0]) | (m_fall & bus.irq_mask[1]) | (m_irq & ~bus.irq_clr);
`ifdef GPI_FILTER_EDGE_COUNT_EN
    if (bus.cnt_clr)                    m_edges = prev_edge ? 1 : 0;
    else if (prev_edge && m_edges < 65535) m_edges++;
`else
    m_edges = 0;
`endif
    m_ste = bus.en ? bus.ste_cfg : 2'b00;
    m_ie  = m_on;
    for (int i = SYNC_STAGES - 1; i > 0; i--) msync[i] = msync[i-1];
    msync[0] = bus.di[0];
    m_rise = n_rise;
    m_fall = n_fall;
    @(posedge clk);
    #1;
    chk("ie", bus.ie, m_ie);
    chk("ste", bus.ste, m_ste);
    chk("level", bus.level, m_level);
    chk("valid", bus.valid, m_valid);
    chk("rise", bus.rise, m_rise);
    chk("fall", bus.fall, m_fall);
    chk("irq", bus.irq, m_irq);
    chk("edge_cnt", bus.edge_cnt, m_edges);
    chk("rise_fall_excl", bus.rise & bus.fall, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen, found;
    bus.en = 0; bus.ste_cfg = 2'b10; bus.debounce = 8'd3; bus.irq_mask = 2'b00;
    bus.irq_clr = 0; bus.cnt_clr = 0; bus.di = 2'b11;
    model_reset();
    #12;
    chk("rst_ie", bus.ie, 0);
    chk("rst_level", bus.level, 1);
    chk("rst_valid", bus.valid, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_edge_cnt", bus.edge_cnt, 0);
    rst_n = 1;

    // Settle
    bus.en = 1;
    cyc();
    chk("settle_ie", bus.ie, 1);
    chk("settle_ste", bus.ste, 2'b10);
    repeat (5) cyc();
    chk("settle_not_yet", bus.valid, 0);
    cyc();
    chk("settle_valid", {bus.valid, bus.level, bus.rise}, 3'b110);

    // Debounce D=3, bit1 held opposite to show it is ignored
    bus.di = 2'b10;
    repeat (5) cyc();
    chk("deb_hold", bus.level, 1);
    cyc();
    chk("deb_fall", {bus.level, bus.fall}, 2'b01);
    cyc();
    chk("deb_fall_once", bus.fall, 0);

    // Glitch rejection from a high level
    bus.di = 2'b11;
    repeat (8) cyc();
    bus.di = 2'b10;
    seen = 0;
    repeat (3) begin cyc(); seen |= bus.rise | bus.fall; end
    bus.di = 2'b11;
    repeat (8) begin cyc(); seen |= bus.rise | bus.fall; end
    chk("glitch_no_pulse", seen, 0);
    chk("glitch_level", bus.level, 1);

    // D=0 single-cycle low glitch
    bus.debounce = 8'd0;
    bus.di = 2'b10;
    cyc();
    bus.di = 2'b11;
    cyc();
    cyc();
    chk("d0_fall", {bus.fall, bus.rise}, 2'b10);
    cyc();
    chk("d0_rise", {bus.fall, bus.rise}, 2'b01);

    // irq masking and set-over-clear
    bus.debounce = 8'd1;
    bus.di = 2'b00;
    repeat (6) cyc();
    bus.irq_mask = 2'b10;
    bus.di = 2'b11;
    repeat (6) cyc();
    chk("irq_rise_masked", bus.irq, 0);
    bus.di = 2'b00;
    repeat (6) cyc();
    chk("irq_on_fall", bus.irq, 1);
    bus.irq_clr = 1;
    cyc();
    bus.irq_clr = 0;
    chk("irq_cleared", bus.irq, 0);
    bus.di = 2'b11;
    repeat (6) cyc();
    bus.di = 2'b00;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin cyc(); found = bus.fall; end
    chk("irq_fall_seen", found, 1);
    bus.irq_clr = 1;
    cyc();
    bus.irq_clr = 0;
    chk("irq_set_wins", bus.irq, 1);

    // Disable mid-qualify
    bus.debounce = 8'd5;
    bus.di = 2'b11;
    repeat (4) cyc();
    bus.en = 0;
    cyc();
    chk("dis_outputs", {bus.ie, bus.valid, bus.level, bus.rise, bus.fall}, 5'b00100);
    chk("dis_irq_held", bus.irq, 1);

    // Async reset mid-qualify
    bus.en = 1;
    repeat (8) cyc();
    bus.di = 2'b00;
    repeat (4) cyc();
    #3 rst_n = 0;
    #1;
    chk("arst_outputs", {bus.ie, bus.valid, bus.level, bus.irq, bus.rise, bus.fall}, 6'b001000);
    chk("arst_ste", bus.ste, 0);
    model_reset();
    #2 rst_n = 1;

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)  bus.di = 2'($urandom);
      if ($urandom_range(0, 40) == 0) bus.debounce = CNT_W'($urandom_range(0, 6));
      bus.irq_mask = 2'($urandom);
      bus.ste_cfg  = 2'($urandom);
      bus.irq_clr  = ($urandom_range(0, 15) == 0);
      bus.cnt_clr  = ($urandom_range(0, 31) == 0);
      bus.en       = ($urandom_range(0, 199) != 0);
      cyc();
    end

`ifdef GPI_FILTER_EDGE_COUNT_EN
    // Drive the counter into saturation with one qualified edge per cycle
    bus.en = 1; bus.debounce = 8'd0; bus.cnt_clr = 0; bus.irq_clr = 0;
    repeat (8) cyc();
    for (int i = 0; i < 65540; i++) begin
      bus.di = ~bus.di;
      cyc();
    end
    chk("edge_cnt_sat", bus.edge_cnt, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
